// File: rtl/reg_file_bank.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_bank
// Brief    : 2^ADDR_W x DATA_W register file, two registered read ports, one
//            write port, same-edge bypass, pending scoreboard, clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_bank #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              regenable,
    input  logic [ADDR_W-1:0] readreg1,
    input  logic [ADDR_W-1:0] readreg2,
    input  logic [ADDR_W-1:0] writereg,
    input  logic [DATA_W-1:0] data_result,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_reg,
    output logic [DATA_W-1:0] data_A,
    output logic [DATA_W-1:0] data_B,
    output logic              ready,
    output logic              hazard
);

    localparam int   DEPTH  = 1 << ADDR_W;
    localparam logic c_zero = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pending;
    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic              r_ready;

    logic              w_zero_a, w_zero_b;
    logic              w_byp_a, w_byp_b;
    logic              w_hz_a, w_hz_b;
    logic [DATA_W-1:0] w_rd_a, w_rd_b;
    logic              w_wr_ok, w_rsv_ok;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;

    // Hardwired-zero addresses never bypass and never report a hazard.
    assign w_zero_a = c_zero && (readreg1 == '0);
    assign w_zero_b = c_zero && (readreg2 == '0);
    assign w_byp_a  = regenable && (writereg == readreg1);
    assign w_byp_b  = regenable && (writereg == readreg2);
    assign w_rd_a   = w_zero_a ? '0 : (w_byp_a ? data_result : r_mem[readreg1]);
    assign w_rd_b   = w_zero_b ? '0 : (w_byp_b ? data_result : r_mem[readreg2]);

    assign w_wr_ok  = regenable && !(c_zero && (writereg == '0));
    assign w_rsv_ok = rsv_en && !(c_zero && (rsv_reg == '0));

    assign w_hz_a   = r_pending[readreg1] && !w_byp_a && !w_zero_a;
    assign w_hz_b   = r_pending[readreg2] && !w_byp_b && !w_zero_b;

    // The sweep owns the array write port until the controller reaches RUN.
    assign w_mem_we   = !reset && ((r_state == ST_CLEAR) || w_wr_ok);
    assign w_mem_addr = (r_state == ST_CLEAR) ? r_clr_cnt : writereg;
    assign w_mem_data = (r_state == ST_CLEAR) ? '0 : data_result;

    always_ff @(negedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_pending <= '0;
            r_data_a  <= '0;
            r_data_b  <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == '1) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        r_data_a <= w_rd_a;
                        r_data_b <= w_rd_b;
                    end
                    // Reservation is applied last so it wins over a same-edge write.
                    if (w_wr_ok) begin
                        r_pending[writereg] <= 1'b0;
                    end
                    if (w_rsv_ok) begin
                        r_pending[rsv_reg] <= 1'b1;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign data_A = r_data_a;
    assign data_B = r_data_b;
    assign ready  = r_ready;
    assign hazard = r_ready && enable && (w_hz_a || w_hz_b);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_bank.sv
`default_nettype none
// Testbench for reg_file_bank: two instances (ZERO_REG = 0 and 1) driven in
// lockstep, checked against directed vectors and a behavioural model.
module tb_reg_file_bank;

    logic        clock = 1'b0;
    logic        reset, enable, regenable, rsv_en;
    logic [2:0]  readreg1, readreg2, writereg, rsv_reg;
    logic [15:0] data_result;
    logic [15:0] da0, db0, da1, db1;
    logic        rdy0, rdy1, hz0, hz1;
    logic        hz0_s, hz1_s;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    reg_file_bank #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .regenable(regenable),
        .readreg1(readreg1), .readreg2(readreg2), .writereg(writereg),
        .data_result(data_result), .rsv_en(rsv_en), .rsv_reg(rsv_reg),
        .data_A(da0), .data_B(db0), .ready(rdy0), .hazard(hz0)
    );

    reg_file_bank #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .regenable(regenable),
        .readreg1(readreg1), .readreg2(readreg2), .writereg(writereg),
        .data_result(data_result), .rsv_en(rsv_en), .rsv_reg(rsv_reg),
        .data_A(da1), .data_B(db1), .ready(rdy1), .hazard(hz1)
    );

    // Reference model: index 0 = plain instance, 1 = hardwired-zero instance.
    logic [15:0] m_reg  [2][8];
    logic        m_pend [2][8];
    logic [15:0] m_a [2];
    logic [15:0] m_b [2];
    int          m_edges = 0;

    function automatic logic is_zero(int d, logic [2:0] a);
        return (d == 1) && (a == 3'd0);
    endfunction

    function automatic logic m_src_hz(int d, logic [2:0] a);
        return m_pend[d][a] && !(regenable && writereg == a) && !is_zero(d, a);
    endfunction

    function automatic logic m_hazard(int d);
        if (m_edges < 8 || !enable) return 1'b0;
        return m_src_hz(d, readreg1) || m_src_hz(d, readreg2);
    endfunction

    function automatic logic [15:0] m_read(int d, logic [2:0] a);
        if (is_zero(d, a)) return 16'h0000;
        if (regenable && writereg == a) return data_result;
        return m_reg[d][a];
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int r = 0; r < 8; r++) begin
                    m_reg[d][r]  = 16'h0000;
                    m_pend[d][r] = 1'b0;
                end
                m_a[d] = 16'h0000;
                m_b[d] = 16'h0000;
            end else if (m_edges >= 8) begin
                if (enable) begin
                    m_a[d] = m_read(d, readreg1);
                    m_b[d] = m_read(d, readreg2);
                end
                if (regenable && !is_zero(d, writereg)) begin
                    m_reg[d][writereg]  = data_result;
                    m_pend[d][writereg] = 1'b0;
                end
                if (rsv_en && !is_zero(d, rsv_reg)) m_pend[d][rsv_reg] = 1'b1;
            end
        end
        if (reset) m_edges = 0;
        else if (m_edges < 8) m_edges++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Called away from clock edges; leaves time 1 unit after the falling edge.
    task automatic cycle(input logic rst, input logic en, input logic wen,
                         input logic [2:0] r1, input logic [2:0] r2,
                         input logic [2:0] wr, input logic [15:0] wd,
                         input logic rsv, input logic [2:0] rr);
        reset = rst; enable = en; regenable = wen; readreg1 = r1; readreg2 = r2;
        writereg = wr; data_result = wd; rsv_en = rsv; rsv_reg = rr;
        #2;
        hz0_s = hz0;
        hz1_s = hz1;
        if (!rst) begin
            chk("model_hazard0", {31'd0, hz0}, {31'd0, m_hazard(0)});
            chk("model_hazard1", {31'd0, hz1}, {31'd0, m_hazard(1)});
        end
        @(negedge clock);
        model_edge();
        #1;
        chk("model_A0", {16'd0, da0}, {16'd0, m_a[0]});
        chk("model_B0", {16'd0, db0}, {16'd0, m_b[0]});
        chk("model_A1", {16'd0, da1}, {16'd0, m_a[1]});
        chk("model_B1", {16'd0, db1}, {16'd0, m_b[1]});
        chk("model_ready0", {31'd0, rdy0}, {31'd0, (m_edges >= 8)});
        chk("model_ready1", {31'd0, rdy1}, {31'd0, (m_edges >= 8)});
    endtask

    typedef struct {
        logic        en, wen;
        logic [2:0]  r1, r2, wr;
        logic [15:0] wd;
        logic        rsv;
        logic [2:0]  rr;
        logic [15:0] a0, b0;
        logic        h0;
        logic [15:0] a1, b1;
        logic        h1;
    } vec_t;

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{1'b1,1'b1,3'd1,3'd0,3'd1,16'hFFFF,1'b0,3'd0, 16'hFFFF,16'h0000,1'b0, 16'hFFFF,16'h0000,1'b0};
        vecs[1]  = '{1'b0,1'b0,3'd0,3'd0,3'd0,16'h0000,1'b0,3'd0, 16'hFFFF,16'h0000,1'b0, 16'hFFFF,16'h0000,1'b0};
        vecs[2]  = '{1'b1,1'b0,3'd1,3'd1,3'd0,16'h0000,1'b0,3'd0, 16'hFFFF,16'hFFFF,1'b0, 16'hFFFF,16'hFFFF,1'b0};
        vecs[3]  = '{1'b0,1'b1,3'd0,3'd0,3'd2,16'h2222,1'b0,3'd0, 16'hFFFF,16'hFFFF,1'b0, 16'hFFFF,16'hFFFF,1'b0};
        vecs[4]  = '{1'b0,1'b1,3'd0,3'd0,3'd2,16'h3333,1'b0,3'd0, 16'hFFFF,16'hFFFF,1'b0, 16'hFFFF,16'hFFFF,1'b0};
        vecs[5]  = '{1'b1,1'b0,3'd2,3'd0,3'd0,16'hFEED,1'b0,3'd0, 16'h3333,16'h0000,1'b0, 16'h3333,16'h0000,1'b0};
        vecs[6]  = '{1'b1,1'b1,3'd0,3'd0,3'd0,16'h4444,1'b0,3'd0, 16'h4444,16'h4444,1'b0, 16'h0000,16'h0000,1'b0};
        vecs[7]  = '{1'b1,1'b0,3'd0,3'd2,3'd0,16'h0000,1'b0,3'd0, 16'h4444,16'h3333,1'b0, 16'h0000,16'h3333,1'b0};
        vecs[8]  = '{1'b0,1'b0,3'd0,3'd0,3'd0,16'h0000,1'b1,3'd4, 16'h4444,16'h3333,1'b0, 16'h0000,16'h3333,1'b0};
        vecs[9]  = '{1'b1,1'b0,3'd4,3'd0,3'd0,16'h0000,1'b0,3'd0, 16'h0000,16'h4444,1'b1, 16'h0000,16'h0000,1'b1};
        vecs[10] = '{1'b1,1'b1,3'd4,3'd4,3'd4,16'h4444,1'b0,3'd0, 16'h4444,16'h4444,1'b0, 16'h4444,16'h4444,1'b0};
        vecs[11] = '{1'b1,1'b0,3'd4,3'd4,3'd0,16'h0000,1'b0,3'd0, 16'h4444,16'h4444,1'b0, 16'h4444,16'h4444,1'b0};
        vecs[12] = '{1'b0,1'b1,3'd0,3'd0,3'd3,16'h3131,1'b1,3'd3, 16'h4444,16'h4444,1'b0, 16'h4444,16'h4444,1'b0};
        vecs[13] = '{1'b1,1'b0,3'd3,3'd1,3'd0,16'h0000,1'b0,3'd0, 16'h3131,16'hFFFF,1'b1, 16'h3131,16'hFFFF,1'b1};
        vecs[14] = '{1'b1,1'b1,3'd3,3'd1,3'd3,16'h5555,1'b0,3'd0, 16'h5555,16'hFFFF,1'b0, 16'h5555,16'hFFFF,1'b0};
        vecs[15] = '{1'b1,1'b0,3'd3,3'd3,3'd0,16'h0000,1'b0,3'd0, 16'h5555,16'h5555,1'b0, 16'h5555,16'h5555,1'b0};
        vecs[16] = '{1'b0,1'b0,3'd0,3'd0,3'd0,16'h0000,1'b1,3'd0, 16'h5555,16'h5555,1'b0, 16'h5555,16'h5555,1'b0};
        vecs[17] = '{1'b1,1'b0,3'd0,3'd1,3'd0,16'h0000,1'b0,3'd0, 16'h4444,16'hFFFF,1'b1, 16'h0000,16'hFFFF,1'b0};

        #1;
        // Reset for two edges, then count the sweep with strobes active.
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 3'd1, 16'hAAAA, 1'b1, 3'd1);
            chk("reset_ready", {31'd0, rdy0}, 32'd0);
            chk("reset_A", {16'd0, da0}, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 3'd1, 3'd2, 3'd1, 16'hABCD, 1'b1, 3'd1);
            chk("sweep_ready", {31'd0, rdy0}, {31'd0, (i == 7)});
            chk("sweep_A", {16'd0, da0}, 32'd0);
            chk("sweep_B", {16'd0, db1}, 32'd0);
        end

        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, vecs[i].en, vecs[i].wen, vecs[i].r1, vecs[i].r2, vecs[i].wr,
                  vecs[i].wd, vecs[i].rsv, vecs[i].rr);
            chk($sformatf("vec%0d_A0", i), {16'd0, da0}, {16'd0, vecs[i].a0});
            chk($sformatf("vec%0d_B0", i), {16'd0, db0}, {16'd0, vecs[i].b0});
            chk($sformatf("vec%0d_hz0", i), {31'd0, hz0_s}, {31'd0, vecs[i].h0});
            chk($sformatf("vec%0d_A1", i), {16'd0, da1}, {16'd0, vecs[i].a1});
            chk($sformatf("vec%0d_B1", i), {16'd0, db1}, {16'd0, vecs[i].b1});
            chk($sformatf("vec%0d_hz1", i), {31'd0, hz1_s}, {31'd0, vecs[i].h1});
        end

        // Fill every register, reset mid-run, and confirm the sweep wipes them.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'(i), 16'(16'h1111 * (i + 1)), 1'b0, 3'd0);
        end
        cycle(1'b0, 1'b1, 1'b0, 3'd7, 3'd2, 3'd0, 16'h0000, 1'b0, 3'd0);
        chk("fill_r7", {16'd0, da0}, 32'h8888);
        chk("fill_r2", {16'd0, db0}, 32'h3333);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 3'd0);
        chk("midreset_ready", {31'd0, rdy0}, 32'd0);
        chk("midreset_A", {16'd0, da0}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 3'd0);
            chk("resweep_ready", {31'd0, rdy1}, {31'd0, (i == 7)});
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 3'(i), 3'(7 - i), 3'd0, 16'h0000, 1'b0, 3'd0);
            chk("cleared_A", {16'd0, da0}, 32'd0);
            chk("cleared_B", {16'd0, db0}, 32'd0);
            chk("cleared_hz", {31'd0, hz0_s}, 32'd0);
        end

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
                  3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
                  ($urandom_range(0, 2) == 0), 3'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_bank.md
# reg_file_bank

Parametrised successor to the 8 x 16-bit processor register file: 2^ADDR_W registers of DATA_W bits, two registered read ports, one write port. Adds optional hardwired-zero r0, same-edge write-to-read bypass, a per-register pending scoreboard for hazard detection, and a sequential post-reset clear sweep. It sits between decode (read addresses, reservations) and writeback (write port) in the RISC datapath. All state updates on the falling edge of clock, as in the existing datapath.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W registers
- ZERO_REG, 0, 1 = r0 reads 0, ignores writes and reservations
- clock  in  1  single clock; all state changes on its falling edge
- reset  in  1  synchronous, active-high; sampled on the falling edge of clock
- enable  in  1  read strobe; latch data_A/data_B on this edge
- regenable  in  1  write strobe
- readreg1  in  ADDR_W  read address, port A
- readreg2  in  ADDR_W  read address, port B
- writereg  in  ADDR_W  write address
- data_result  in  DATA_W  write data
- rsv_en  in  1  reserve strobe: mark rsv_reg pending
- rsv_reg  in  ADDR_W  register to reserve
- data_A  out  DATA_W  registered read data, port A
- data_B  out  DATA_W  registered read data, port B
- ready  out  1  registered; 1 once the clear sweep is complete
- hazard  out  1  combinational; a read source is pending and not bypassed

## Operation
- Controller states: CLEAR, RUN. Reset -> CLEAR, clr_cnt = 0.
- CLEAR: each non-reset edge writes 0 to reg[clr_cnt] and increments clr_cnt. The edge that clears reg[DEPTH-1] moves the controller to RUN and sets ready = 1. enable, regenable and rsv_en are ignored in CLEAR. data_A and data_B hold 0.
- RUN, write: if regenable, reg[writereg] <= data_result and pending[writereg] <= 0. With ZERO_REG=1 and writereg = 0, the write is discarded.
- RUN, read: if enable, data_A <= reg[readreg1] and data_B <= reg[readreg2]. Otherwise both outputs hold.
  - Bypass: if regenable and writereg == readreg1 on the same edge, data_A <= data_result. Port B likewise.
  - With ZERO_REG=1, address 0 always reads 0, with no bypass.
- RUN, reserve: if rsv_en, pending[rsv_reg] <= 1. If a write and a reservation hit the same register on one edge, the reservation wins and pending stays 1.
- hazard = ready & enable & (hzA | hzB).
  - hzA = pending[readreg1] & !(regenable & writereg == readreg1) & !(ZERO_REG & readreg1 == 0).
  - hzB is the same for readreg2.
  - hazard is advisory: the read still occurs, and decode must stall and re-read.
- Reset mid-operation (in either state) restarts the full sweep.
  - Contents are lost. data_A, data_B, ready and all pending bits go to 0.

## Timing
- Reset values: data_A = 0, data_B = 0, ready = 0, pending = all 0, clr_cnt = 0, state CLEAR. hazard = 0 because ready = 0.
- ready rises exactly DEPTH falling edges after the first edge with reset = 0 (8 edges at the defaults).
- Read latency: one falling edge from enable to data_A/data_B.
- Write latency: one edge. The same-edge read returns the new value via bypass; a read one edge later returns it from the array.
- pending sets on the rsv_en edge and is visible to hazard immediately afterwards. It clears on the write edge.
- The write port has no back-pressure; one write per edge.

## Test plan
- Reset 2 edges, release, count edges -> ready = 0 for 7 falling edges and 1 after the 8th. data_A = data_B = 0 throughout.
- After ready: write 0xFFFF to r1 with enable=1, readreg1=1, same edge -> data_A = 0xFFFF on that edge (bypass). Read r1 two edges later -> 0xFFFF from the array.
- Write 0x2222 then 0x3333 to r2 on consecutive edges, then write 0xFEED to r0 with regenable = 0 -> r2 reads 0x3333 and r0 is unchanged. With ZERO_REG=1, a write of 0x4444 to r0 -> r0 reads 0.
- rsv_en on r4, then enable with readreg1=4 -> hazard = 1. Then write 0x4444 to r4 with enable on the same edge -> hazard = 0 and data_A = 0x4444. pending[r4] clears.
- Reserve and write r3 on the same edge -> next read of r3 with enable gives hazard = 1 (reservation wins).
- Fill r0–r7 with 0x1111–0x8888, assert reset for 1 edge mid-run, release -> ready drops to 0, returns after 8 edges, and all registers read 0.
